// File: rtl/l2cache_mem_responder.sv
// L2 line refill/writeback responder: one line <-> N single-word accesses, one outstanding, write drain has priority.
// addrOK same cycle as request; refill after any pending drain; dataOK waits for rdy. Option: `L2MEM_RAW_BYPASS_EN.
module l2cache_mem_responder #(
  parameter int ADDR_WIDTH   = 32,
  parameter int WORD_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  l2cache_mem_req_r,
  input  logic                                  l2cache_mem_req_w,
  input  logic                                  l2cache_mem_rdy,
  input  logic [ADDR_WIDTH-1:0]                 l2cache_mem_addr_r,
  input  logic [ADDR_WIDTH-1:0]                 l2cache_mem_addr_w,
  input  logic [(WORD_WIDTH<<OFFSET_WIDTH)-1:0] l2cache_mem_wdata,
  output logic                                  mem_l2cache_addrOK_r,
  output logic                                  mem_l2cache_addrOK_w,
  output logic                                  mem_l2cache_dataOK,
  output logic [(WORD_WIDTH<<OFFSET_WIDTH)-1:0] mem_l2cache_rdata,
  output logic                                  mem_req,
  output logic                                  mem_we,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [WORD_WIDTH-1:0]                 mem_wdata,
  input  logic                                  mem_gnt,
  input  logic                                  mem_rvalid,
  input  logic [WORD_WIDTH-1:0]                 mem_rdata
);

  localparam int LINE_WIDTH = WORD_WIDTH << OFFSET_WIDTH;
  localparam int BYTE_OFF   = $clog2(WORD_WIDTH / 8);
  localparam int LINE_OFF   = OFFSET_WIDTH + BYTE_OFF;
  localparam logic [ADDR_WIDTH-1:0]   LINE_MASK = ADDR_WIDTH'((64'd1 << LINE_OFF) - 64'd1);
  localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = '1;

  typedef enum logic {W_IDLE, W_DRAIN} w_state_t;
  typedef enum logic [2:0] {R_IDLE, R_WAITW, R_FETCH, R_RWAIT, R_RESP} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [ADDR_WIDTH-1:0]   w_base, r_base;
  logic [LINE_WIDTH-1:0]   w_buf, rdata_q;
  logic [OFFSET_WIDTH-1:0] w_cnt, r_cnt;
  logic                    rd_hold;
  logic                    w_accept, r_accept, w_busy, w_go, r_go, raw_hit;

  assign w_accept = rstn && (w_state == W_IDLE) && l2cache_mem_req_w;
  assign r_accept = rstn && (r_state == R_IDLE) && l2cache_mem_req_r;
  assign w_busy   = (w_state == W_DRAIN) || w_accept;

  // Drain wins the port, but never yanks a read that is already presented and ungranted,
  // and never issues while a read word is outstanding.
  assign w_go = (w_state == W_DRAIN) && !rd_hold && (r_state != R_RWAIT);
  assign r_go = (r_state == R_FETCH) && ((w_state != W_DRAIN) || rd_hold);

`ifdef L2MEM_RAW_BYPASS_EN
  assign raw_hit = ((w_state == W_DRAIN) && (w_base == r_base)) ||
                   (w_accept && ((l2cache_mem_addr_w & ~LINE_MASK) == r_base));
`else
  assign raw_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (w_accept) w_state_nxt = W_DRAIN;
      W_DRAIN: if (w_go && mem_gnt && (w_cnt == LAST_WORD)) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (r_accept) r_state_nxt = R_WAITW;
      R_WAITW: begin
        if (raw_hit)      r_state_nxt = R_RESP;
        else if (!w_busy) r_state_nxt = R_FETCH;
      end
      R_FETCH: if (r_go && mem_gnt) r_state_nxt = R_RWAIT;
      R_RWAIT: if (mem_rvalid) r_state_nxt = (r_cnt == LAST_WORD) ? R_RESP : R_FETCH;
      R_RESP:  if (l2cache_mem_rdy) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      w_base  <= '0;
      r_base  <= '0;
      w_buf   <= '0;
      rdata_q <= '0;
      w_cnt   <= '0;
      r_cnt   <= '0;
      rd_hold <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
      rd_hold <= r_go && !mem_gnt;
      if (w_accept) begin
        w_base <= l2cache_mem_addr_w & ~LINE_MASK;
        w_buf  <= l2cache_mem_wdata;
      end
      if (w_go && mem_gnt) w_cnt <= w_cnt + 1'b1;
      if (r_accept) r_base <= l2cache_mem_addr_r & ~LINE_MASK;
      if ((r_state == R_RWAIT) && mem_rvalid) begin
        rdata_q[int'(r_cnt)*WORD_WIDTH +: WORD_WIDTH] <= mem_rdata;
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == R_WAITW) && raw_hit)
        rdata_q <= (w_state == W_DRAIN) ? w_buf : l2cache_mem_wdata;
    end
  end

  // Word index is ORed into the zeroed offset field so it can never carry into the tag.
  assign mem_req   = w_go || r_go;
  assign mem_we    = w_go;
  assign mem_addr  = w_go ? (w_base | (ADDR_WIDTH'(w_cnt) << BYTE_OFF)) :
                     r_go ? (r_base | (ADDR_WIDTH'(r_cnt) << BYTE_OFF)) : '0;
  assign mem_wdata = w_go ? w_buf[int'(w_cnt)*WORD_WIDTH +: WORD_WIDTH] : '0;

  assign mem_l2cache_addrOK_w = w_accept;
  assign mem_l2cache_addrOK_r = r_accept;
  assign mem_l2cache_dataOK   = (r_state == R_RESP) && l2cache_mem_rdy;
  assign mem_l2cache_rdata    = rdata_q;

endmodule

// File: tb/tb_l2cache_mem_responder.sv
// Randomized bench for l2cache_mem_responder: word-level memory behind the port plus a line-level reference model.
`timescale 1ns/1ps
module tb_l2cache_mem_responder;
  localparam int AW = 32, WW = 32, OW = 2, N = 1 << OW, LW = WW << OW;
`ifdef L2MEM_RAW_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0, rstn = 1'b0;
  logic req_r = 1'b0, req_w = 1'b0, rdy = 1'b0;
  logic [AW-1:0] addr_r = '0, addr_w = '0;
  logic [LW-1:0] wdata = '0;
  logic aok_r, aok_w, dok;
  logic [LW-1:0] rdata;
  logic mem_req, mem_we, mem_gnt;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic mem_rvalid = 1'b0;
  logic [WW-1:0] mem_rdata = '0;
  logic gnt_en = 1'b1;

  assign mem_gnt = mem_req & gnt_en;
  always #5 clk = ~clk;

  l2cache_mem_responder #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .OFFSET_WIDTH(OW)) dut (
    .clk(clk), .rstn(rstn),
    .l2cache_mem_req_r(req_r), .l2cache_mem_req_w(req_w), .l2cache_mem_rdy(rdy),
    .l2cache_mem_addr_r(addr_r), .l2cache_mem_addr_w(addr_w), .l2cache_mem_wdata(wdata),
    .mem_l2cache_addrOK_r(aok_r), .mem_l2cache_addrOK_w(aok_w), .mem_l2cache_dataOK(dok),
    .mem_l2cache_rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference view of memory (updated when a line write is accepted) and the storage behind the port.
  logic [WW-1:0] ref_mem [bit [AW-1:0]];
  logic [WW-1:0] store   [bit [AW-1:0]];
  typedef struct packed {logic [AW-1:0] a; logic [WW-1:0] d;} wacc_t;
  wacc_t         exp_wq[$];
  logic [AW-1:0] exp_rq[$];
  logic [WW-1:0] rsp_d[$];
  int            rsp_t[$];

  logic [LW-1:0] exp_rline, mon_rdata;
  bit rd_pend, bypass_hit, seek_first, prev_stall, saw_rd_w1, mon_aokr, mon_aokw, mon_dok;
  logic [AW+WW+1:0] prev_port;
  int cyc, t_aokr, t_first_req, t_dok, rd_acc_cnt, rv_cnt, rv_max;
  int gnt_mode, rdy_mode, stall_budget, stall_used;

  function automatic logic [WW-1:0] init_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction
  function automatic logic [AW-1:0] base_of(input logic [AW-1:0] a);
    return a & ~32'hF;
  endfunction
  function automatic logic [LW-1:0] ref_line(input logic [AW-1:0] b);
    logic [LW-1:0] l;
    for (int k = 0; k < N; k++)
      l[k*WW +: WW] = ref_mem.exists(b + 4*k) ? ref_mem[b + 4*k] : init_word(b + 4*k);
    return l;
  endfunction

  task automatic monitor();
    logic [AW-1:0] b;
    wacc_t e;
    mon_aokr = aok_r; mon_aokw = aok_w; mon_dok = dok; mon_rdata = rdata;
    if (!rstn) begin
      exp_wq.delete(); exp_rq.delete(); rsp_d.delete(); rsp_t.delete();
      rd_pend = 0; prev_stall = 0; seek_first = 0;
      return;
    end
    if (prev_stall) check("port_hold", {mem_req, mem_we, mem_addr, mem_wdata}, prev_port);
    if (rsp_d.size() > 0) check("req_while_outstanding", mem_req, 0);
    if (aok_w) begin
      check("aokw_while_draining", exp_wq.size(), 0);
      b = base_of(addr_w);
      for (int k = 0; k < N; k++) begin
        ref_mem[b + 4*k] = wdata[k*WW +: WW];
        exp_wq.push_back({b + 32'(4*k), wdata[k*WW +: WW]});
      end
    end
    if (aok_r) begin
      check("aokr_while_busy", rd_pend, 0);
      b = base_of(addr_r);
      rd_pend = 1; exp_rline = ref_line(b); t_aokr = cyc; seek_first = 1;
      if (!bypass_hit) for (int k = 0; k < N; k++) exp_rq.push_back(b + 4*k);
    end
    if (mem_req && seek_first) begin t_first_req = cyc; seek_first = 0; end
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        check("write_expected", exp_wq.size() > 0, 1);
        if (exp_wq.size() > 0) begin e = exp_wq.pop_front(); check("write_access", {mem_addr, mem_wdata}, e); end
        store[mem_addr] = mem_wdata;
      end else begin
        check("refill_after_drain", exp_wq.size(), 0);
        check("read_expected", exp_rq.size() > 0, 1);
        if (exp_rq.size() > 0) check("read_addr", mem_addr, exp_rq.pop_front());
        rsp_d.push_back(store.exists(mem_addr) ? store[mem_addr] : init_word(mem_addr));
        rsp_t.push_back(cyc + 1 + int'($urandom_range(0, rv_max)));
        rd_acc_cnt++;
        if (mem_addr[3:2] == 2'd1) saw_rd_w1 = 1;
      end
    end
    if (mem_rvalid && rsp_d.size() > 0) begin void'(rsp_d.pop_front()); void'(rsp_t.pop_front()); rv_cnt++; end
    if (dok) begin
      check("dataok_pending", rd_pend, 1);
      check("dataok_rdy", rdy, 1);
      check("rdata", rdata, exp_rline);
      rd_pend = 0; t_dok = cyc;
    end
    prev_stall = mem_req && !mem_gnt;
    prev_port  = {mem_req, mem_we, mem_addr, mem_wdata};
  endtask

  task automatic drive_mem();
    mem_rvalid = 1'b0;
    if (rstn && rsp_t.size() > 0 && rsp_t[0] <= cyc) begin mem_rvalid = 1'b1; mem_rdata = rsp_d[0]; end
    case (gnt_mode)
      1: gnt_en = ($urandom_range(0, 3) != 0);
      2: if (mem_req && mem_addr[3:2] == 2'd2 && stall_used < stall_budget) begin
           gnt_en = 1'b0; stall_used++;
         end else gnt_en = 1'b1;
      default: gnt_en = 1'b1;
    endcase
    if (rdy_mode != 0) rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic step();
    @(negedge clk); monitor();
    @(posedge clk); #1; cyc++; drive_mem();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 500 && (rd_pend || exp_wq.size() > 0 || rsp_d.size() > 0); i++) step();
    check("txn_done", {rd_pend, exp_wq.size() > 0}, 0);
  endtask

  task automatic txn(input bit hw, input logic [AW-1:0] wa, input logic [LW-1:0] wd,
                     input bit hr, input logic [AW-1:0] ra, input bit r_later);
    int rd0;
    rd0 = rd_acc_cnt;
    bypass_hit = BYP && hw && hr && (base_of(wa) == base_of(ra));
    if (hw) begin req_w = 1; addr_w = wa; wdata = wd; end
    if (hr && !r_later) begin req_r = 1; addr_r = ra; end
    step();
    if (hw) check("addrOK_w", mon_aokw, 1);
    if (hr && !r_later) check("addrOK_r", mon_aokr, 1);
    req_w = 0; req_r = 0;
    if (hr && r_later) begin
      req_r = 1; addr_r = ra; step();
      check("addrOK_r_late", mon_aokr, 1);
      req_r = 0;
    end
    wait_done();
    check("read_count", rd_acc_cnt - rd0, (hr && !bypass_hit) ? N : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv0;
    logic [AW-1:0] wa, ra;
    bit hw, hr;
    rv_max = 0; gnt_mode = 0; rdy_mode = 0;
    req_r = 1; req_w = 1; addr_r = 32'h1234; addr_w = 32'h5678; wdata = '1; rdy = 1;
    #12;
    check("reset_outputs", {aok_r, aok_w, dok, rdata, mem_req, mem_we, mem_addr, mem_wdata}, 0);
    @(posedge clk); #1;
    req_r = 0; req_w = 0;
    step(); step();
    rstn = 1;
    step();
    check("idle_after_reset", {aok_r, aok_w, dok, mem_req}, 0);

    // Clean read with zero-wait grant and 1-cycle rvalid: latency check.
    txn(0, '0, '0, 1, 32'h0000_1004, 0);
    check("lat_first_req", t_first_req - t_aokr, 2);
    check("lat_dataok", t_dok - t_aokr, 2 + 2*N);

    // Writeback and refill in the same cycle.
    txn(1, 32'h0000_2000, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA, 1, 32'h0000_3000, 0);

    // rdy backpressure after the fetch completes.
    rdy = 0; bypass_hit = 0; addr_r = 32'h0000_5008; req_r = 1; rv0 = rv_cnt;
    step();
    check("bp_addrOK_r", mon_aokr, 1);
    req_r = 0;
    for (int i = 0; i < 100 && rv_cnt - rv0 < N; i++) step();
    check("bp_fetch_done", rv_cnt - rv0, N);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_dataok_low", mon_dok, 0);
      check("bp_rdata_stable", mon_rdata, exp_rline);
    end
    rdy = 1; step();
    check("bp_dataok_rise", mon_dok, 1);
    step();
    check("bp_dataok_once", mon_dok, 0);

    // Grant stall on word 2 for a write and then a read.
    gnt_mode = 2; stall_budget += 3;
    txn(1, 32'h0000_2400, {$urandom, $urandom, $urandom, $urandom}, 0, '0, 0);
    stall_budget += 3;
    txn(0, '0, '0, 1, 32'h0000_2400, 0);
    check("stall_applied", stall_used, stall_budget);
    gnt_mode = 0;

    // Reset after the grant of read word 1, then a fresh read.
    rv_max = 2; saw_rd_w1 = 0; bypass_hit = 0; addr_r = 32'h0000_6000; req_r = 1;
    step();
    req_r = 0;
    for (int i = 0; i < 100 && !saw_rd_w1; i++) step();
    check("rst_reached_word1", saw_rd_w1, 1);
    rstn = 0; #1;
    check("rst_mid_outputs", {aok_r, aok_w, dok, rdata, mem_req, mem_we, mem_addr, mem_wdata}, 0);
    step(); step();
    rstn = 1;
    txn(0, '0, '0, 1, 32'h0000_6004, 0);

    // Write followed by a read of the same line (served from the write buffer when bypass is built in).
    txn(1, 32'h0000_4000, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1, 32'h0000_4000, 1);

    // Random mix with grant stalls, rvalid delay and rdy toggling.
    gnt_mode = 1; rdy_mode = 1; rv_max = 2;
    for (int n = 0; n < 40; n++) begin
      hw = 1'($urandom_range(0, 1));
      hr = hw ? 1'($urandom_range(0, 1)) : 1'b1;
      wa = 32'h0000_7000 + 32'(16 * $urandom_range(0, 3)) + 32'($urandom_range(0, 15));
      ra = 32'h0000_7000 + 32'(16 * $urandom_range(0, 3)) + 32'($urandom_range(0, 15));
      txn(hw, wa, {$urandom, $urandom, $urandom, $urandom}, hr, ra, hw && 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
